// File: rtl/mem_bridge_pkg.sv
// Shared types and sizing for the RAM mux secondary-port request bridge.
// MEM_BRIDGE_NARROW_EN adds a per-request is_32b flag to mem_req_t.
package mem_bridge_pkg;
  localparam int MB_ADDR_WIDTH = 32;
  localparam int MB_DATA_WIDTH = 128;
  localparam int MB_REQ_DEPTH  = 4;
  localparam int MB_RSP_DEPTH  = 4;

  typedef struct packed {
    logic [MB_ADDR_WIDTH-1:0]   addr;
    logic                       we;
    logic [MB_DATA_WIDTH/8-1:0] be;
    logic [MB_DATA_WIDTH-1:0]   wdata;
`ifdef MEM_BRIDGE_NARROW_EN
    logic                       is_32b;
`endif
  } mem_req_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/mem_bridge_fifo.sv
// Type/depth parameterised synchronous FIFO; head entry read straight from storage.
// Push while full is accepted only when a pop happens in the same cycle.
module mem_bridge_fifo
  import mem_bridge_pkg::*;
#(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              wdata,
  input  logic          pop,
  output T              rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic           do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers/count gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/mem_req_bridge.sv
// valid/ready request/response streams to RAM mux req/gnt/rvalid port, with response credit.
// Define MEM_BRIDGE_NARROW_EN to carry req_is_32b_i through to mem_is_32b_o.
module mem_req_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = MB_ADDR_WIDTH,
  parameter int DATA_WIDTH = MB_DATA_WIDTH,
  parameter int REQ_DEPTH  = MB_REQ_DEPTH,
  parameter int RSP_DEPTH  = MB_RSP_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_we_i,
  input  logic [DATA_WIDTH/8-1:0] req_be_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
`ifdef MEM_BRIDGE_NARROW_EN
  input  logic                    req_is_32b_i,
`endif
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    mem_is_32b_o,
  output logic                    busy_o
);
  localparam int RCW = cnt_width(REQ_DEPTH);
  localparam int SCW = cnt_width(RSP_DEPTH);

  mem_req_t              req_in, head;
  logic                  req_full, req_empty, req_push, req_pop;
  logic [RCW-1:0]        req_count;
  logic                  rsp_full, rsp_empty, rsp_push, rsp_pop;
  logic [SCW-1:0]        rsp_count;
  logic [DATA_WIDTH-1:0] rsp_head;
  logic [SCW:0]          rsp_used;
  logic                  inflight_q, inflight_rd_q, credit_ok, grant;

  always_comb begin
    req_in       = '0;
    req_in.addr  = req_addr_i;
    req_in.we    = req_we_i;
    req_in.be    = req_be_i;
    req_in.wdata = req_wdata_i;
`ifdef MEM_BRIDGE_NARROW_EN
    req_in.is_32b = req_is_32b_i;
`endif
  end

  assign req_ready_o = !req_full & !rst;
  assign req_push    = req_valid_i & req_ready_o;

  mem_bridge_fifo #(.T(mem_req_t), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk(clk), .rst(rst), .push(req_push), .wdata(req_in), .pop(req_pop),
    .rdata(head), .full(req_full), .empty(req_empty), .count(req_count)
  );

  // rvalid has no backpressure, so a read only issues with a response slot reserved.
  // A returning read moves its reservation from inflight to the FIFO, so credit never shrinks.
  assign rsp_used  = {1'b0, rsp_count} + {{SCW{1'b0}}, inflight_rd_q};
  assign credit_ok = !rsp_full & (rsp_used < (SCW+1)'(RSP_DEPTH));
  assign mem_req_o = !req_empty & (head.we | credit_ok);
  assign grant     = mem_req_o & mem_gnt_i;
  assign req_pop   = grant;

  assign mem_addr_o  = mem_req_o ? head.addr  : '0;
  assign mem_we_o    = mem_req_o & head.we;
  assign mem_be_o    = mem_req_o ? head.be    : '0;
  assign mem_wdata_o = mem_req_o ? head.wdata : '0;
`ifdef MEM_BRIDGE_NARROW_EN
  assign mem_is_32b_o = mem_req_o & head.is_32b;
`else
  assign mem_is_32b_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q    <= 1'b0;
      inflight_rd_q <= 1'b0;
    end else begin
      inflight_q    <= grant;
      inflight_rd_q <= grant & !head.we;
    end
  end

  // Write completions and stray rvalids never reach the response FIFO.
  assign rsp_push    = mem_rvalid_i & inflight_rd_q;
  assign rsp_valid_o = !rsp_empty;
  assign rsp_pop     = rsp_valid_o & rsp_ready_i;
  assign rsp_rdata_o = rsp_valid_o ? rsp_head : '0;

  mem_bridge_fifo #(.T(logic [DATA_WIDTH-1:0]), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk(clk), .rst(rst), .push(rsp_push), .wdata(mem_rdata_i), .pop(rsp_pop),
    .rdata(rsp_head), .full(rsp_full), .empty(rsp_empty), .count(rsp_count)
  );

  assign busy_o = (req_count != '0) | inflight_q | !rsp_empty;
endmodule

// File: tb/tb_mem_req_bridge.sv
// Directed bench for mem_req_bridge with a simple RAM mux model behind port1.
module tb_mem_req_bridge;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int BW = DW/8;
  localparam logic [31:0] KEY = 32'h1234_5678;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req_valid_i = 1'b0, req_we_i = 1'b0, req_is_32b_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [BW-1:0] req_be_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic          rsp_ready_i = 1'b1, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          req_ready_o, rsp_valid_o, mem_req_o, mem_we_o, mem_is_32b_o, busy_o;
  logic [DW-1:0] rsp_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_be_o;

  int total = 0, bad = 0;
  int grant_cnt = 0;
  logic [DW-1:0] rsp_q[$];
  logic gnt_en = 1'b0, inject = 1'b0;

  mem_req_bridge dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
`ifdef MEM_BRIDGE_NARROW_EN
    .req_is_32b_i(req_is_32b_i),
`endif
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_is_32b_o(mem_is_32b_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [31:0] a);
    return {4{a ^ KEY}};
  endfunction

  // RAM mux model: grants when gnt_en, returns rvalid one cycle after each grant.
  initial begin : mux_model
    logic [DW-1:0] mm [logic [31:0]];
    logic [DW-1:0] cur, pend_rd;
    logic pend_v;
    pend_v = 1'b0;
    pend_rd = '0;
    forever begin
      @(negedge clk);
      if (rsp_valid_o && rsp_ready_i) rsp_q.push_back(rsp_rdata_o);
      if (mem_req_o && mem_gnt_i) begin
        grant_cnt++;
        pend_v = 1'b1;
        cur = mm.exists(mem_addr_o) ? mm[mem_addr_o] : pat(mem_addr_o);
        if (mem_we_o) begin
          for (int b = 0; b < BW; b++)
            if (mem_be_o[b]) cur[b*8 +: 8] = mem_wdata_o[b*8 +: 8];
          mm[mem_addr_o] = cur;
          pend_rd = {4{32'hDEAD_BEEF}};
        end else begin
          pend_rd = cur;
        end
      end
      @(posedge clk);
      #2;
      mem_rvalid_i = pend_v | inject;
      mem_rdata_i  = pend_v ? pend_rd : {4{32'h0BAD_0BAD}};
      pend_v       = 1'b0;
      mem_gnt_i    = gnt_en;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] a, input logic we, input logic [BW-1:0] be,
                          input logic [DW-1:0] wd);
    int t = 0;
    req_valid_i = 1'b1; req_addr_i = a; req_we_i = we; req_be_i = be; req_wdata_i = wd;
    while (!req_ready_o && t < 50) begin cyc(); t++; end
    total++;
    if (req_ready_o !== 1'b1) begin bad++; $display("FAIL send_timeout: req_ready_o=%b want 1", req_ready_o); end
    cyc();
    req_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", req_ready_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req_o); end
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    rst = 1'b0;
    cyc();
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b want 1", req_ready_o); end
  endtask

  task automatic test_single_read();
    int g0 = grant_cnt;
    gnt_en = 1'b1; rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_addr_i = 32'h40; req_we_i = 1'b0; req_be_i = '1; req_wdata_i = '0;
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL sr_no_bypass: got %b want 0", mem_req_o); end
    cyc();
    req_valid_i = 1'b0;
    total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL sr_req_n1: got %b want 1", mem_req_o); end
    total++; if (mem_addr_o !== 32'h40) begin bad++; $display("FAIL sr_addr: got %h want 40", mem_addr_o); end
    total++; if (mem_we_o !== 1'b0) begin bad++; $display("FAIL sr_we: got %b want 0", mem_we_o); end
    cyc();
    total++; if (grant_cnt - g0 !== 1) begin bad++; $display("FAIL sr_grants: got %0d want 1", grant_cnt - g0); end
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL sr_rsp_early: got %b want 0", rsp_valid_o); end
    cyc();
    total++; if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL sr_rsp_n3: got %b want 1", rsp_valid_o); end
    total++; if (rsp_rdata_o !== 128'h12345638123456381234563812345638) begin
      bad++; $display("FAIL sr_rdata: got %h want 12345638x4", rsp_rdata_o); end
    cyc();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL sr_idle: busy=%b want 0", busy_o); end
  endtask

  task automatic test_write_read();
    int g0 = grant_cnt, r0 = rsp_q.size();
    send_req(32'h80, 1'b1, '1, {BW{8'hA5}});
    send_req(32'h80, 1'b0, '1, '0);
    repeat (8) cyc();
    total++; if (grant_cnt - g0 !== 2) begin bad++; $display("FAIL wr_grants: got %0d want 2", grant_cnt - g0); end
    total++; if (rsp_q.size() - r0 !== 1) begin bad++; $display("FAIL wr_rsp_count: got %0d want 1", rsp_q.size() - r0); end
    if (rsp_q.size() > r0) begin
      total++; if (rsp_q[r0] !== {BW{8'hA5}}) begin bad++; $display("FAIL wr_rdata: got %h want A5..A5", rsp_q[r0]); end
    end
  endtask

  task automatic test_gnt_stall();
    int g0 = grant_cnt, r0 = rsp_q.size();
    gnt_en = 1'b0;
    send_req(32'h100, 1'b0, 16'h00FF, {4{32'h5555_AAAA}});
    for (int i = 0; i < 5; i++) begin
      total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL st_req[%0d]: got %b want 1", i, mem_req_o); end
      total++; if (mem_addr_o !== 32'h100 || mem_be_o !== 16'h00FF || mem_wdata_o !== {4{32'h5555_AAAA}}) begin
        bad++; $display("FAIL st_fields[%0d]: addr=%h be=%h wdata=%h want 100/00ff/5555aaaa", i, mem_addr_o, mem_be_o, mem_wdata_o); end
`ifndef MEM_BRIDGE_NARROW_EN
      total++; if (mem_is_32b_o !== 1'b0) begin bad++; $display("FAIL st_is32[%0d]: got %b want 0", i, mem_is_32b_o); end
`endif
      cyc();
    end
    total++; if (grant_cnt - g0 !== 0) begin bad++; $display("FAIL st_no_grant: got %0d want 0", grant_cnt - g0); end
    gnt_en = 1'b1;
    repeat (5) cyc();
    total++; if (grant_cnt - g0 !== 1) begin bad++; $display("FAIL st_grants: got %0d want 1", grant_cnt - g0); end
    total++; if (rsp_q.size() - r0 !== 1) begin bad++; $display("FAIL st_rsp_count: got %0d want 1", rsp_q.size() - r0); end
    if (rsp_q.size() > r0) begin
      total++; if (rsp_q[r0] !== 128'h12345778123457781234577812345778) begin
        bad++; $display("FAIL st_rdata: got %h want 12345778x4", rsp_q[r0]); end
    end
  endtask

  task automatic test_credit();
    int g0 = grant_cnt, r0 = rsp_q.size();
    rsp_ready_i = 1'b0; gnt_en = 1'b1;
    for (int i = 0; i < 6; i++) send_req(32'h200 + 32'(16*i), 1'b0, '1, '0);
    repeat (4) cyc();
    total++; if (grant_cnt - g0 !== 4) begin bad++; $display("FAIL cr_grants: got %0d want 4", grant_cnt - g0); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL cr_req_held: got %b want 0", mem_req_o); end
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL cr_ready_2q: got %b want 1", req_ready_o); end
    for (int i = 6; i < 8; i++) send_req(32'h200 + 32'(16*i), 1'b0, '1, '0);
    cyc();
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL cr_ready_full: got %b want 0", req_ready_o); end
    total++; if (grant_cnt - g0 !== 4) begin bad++; $display("FAIL cr_grants_full: got %0d want 4", grant_cnt - g0); end
    rsp_ready_i = 1'b1;
    repeat (20) cyc();
    total++; if (rsp_q.size() - r0 !== 8) begin bad++; $display("FAIL cr_rsp_count: got %0d want 8", rsp_q.size() - r0); end
    for (int i = 0; i < 8; i++) begin
      if (rsp_q.size() > r0 + i) begin
        total++; if (rsp_q[r0+i] !== pat(32'h200 + 32'(16*i))) begin
          bad++; $display("FAIL cr_order[%0d]: got %h want %h", i, rsp_q[r0+i], pat(32'h200 + 32'(16*i))); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int g0 = grant_cnt, r0;
    gnt_en = 1'b0; rsp_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) send_req(32'h300 + 32'(16*i), 1'b0, '1, '0);
    gnt_en = 1'b1;
    cyc();
    gnt_en = 1'b0; rst = 1'b1;
    total++; if (grant_cnt - g0 !== 1) begin bad++; $display("FAIL rm_grant: got %0d want 1", grant_cnt - g0); end
    cyc();
    r0 = rsp_q.size();
    total++; if ({mem_req_o, req_ready_o, rsp_valid_o, busy_o, mem_we_o, mem_is_32b_o} !== 6'b0) begin
      bad++; $display("FAIL rm_ctrl: req/rdy/rsp/busy/we/n32=%b want 000000",
                      {mem_req_o, req_ready_o, rsp_valid_o, busy_o, mem_we_o, mem_is_32b_o}); end
    total++; if (mem_addr_o !== '0 || mem_be_o !== '0 || mem_wdata_o !== '0 || rsp_rdata_o !== '0) begin
      bad++; $display("FAIL rm_data: addr=%h be=%h wdata=%h rdata=%h want 0", mem_addr_o, mem_be_o, mem_wdata_o, rsp_rdata_o); end
    rst = 1'b0;
    inject = 1'b1;
    cyc();
    inject = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
        bad++; $display("FAIL rm_after[%0d]: rsp_valid=%b busy=%b ready=%b want 0/0/1", i, rsp_valid_o, busy_o, req_ready_o); end
    end
    total++; if (rsp_q.size() !== r0) begin bad++; $display("FAIL rm_no_rsp: got %0d want %0d", rsp_q.size(), r0); end
  endtask

`ifdef MEM_BRIDGE_NARROW_EN
  task automatic test_narrow();
    int r0 = rsp_q.size();
    gnt_en = 1'b0; rsp_ready_i = 1'b1;
    req_is_32b_i = 1'b1;
    send_req(32'h08, 1'b0, 16'h000F, '0);
    req_is_32b_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (mem_req_o !== 1'b1 || mem_is_32b_o !== 1'b1) begin
        bad++; $display("FAIL nw_is32[%0d]: req=%b is32=%b want 1/1", i, mem_req_o, mem_is_32b_o); end
      cyc();
    end
    gnt_en = 1'b1;
    cyc();
    total++; if (mem_is_32b_o !== 1'b0) begin bad++; $display("FAIL nw_is32_drop: got %b want 0", mem_is_32b_o); end
    repeat (4) cyc();
    total++; if (rsp_q.size() - r0 !== 1) begin bad++; $display("FAIL nw_rsp_count: got %0d want 1", rsp_q.size() - r0); end
    if (rsp_q.size() > r0) begin
      total++; if (rsp_q[r0] !== 128'h12345670123456701234567012345670) begin
        bad++; $display("FAIL nw_rdata: got %h want 12345670x4", rsp_q[r0]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_gnt_stall();
    test_credit();
    test_reset_mid();
`ifdef MEM_BRIDGE_NARROW_EN
    test_narrow();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
